// File: rtl/morse_pkg.sv
// Shared definitions for the Morse texter: FSM state encoding and default timing thresholds.
// texter_control imports the same threshold defaults so both blocks agree on symbol timing.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    STUCK = 2'd3
  } state_t;

  localparam int CNT_W_DEF     = 8;
  localparam int DEBOUNCE_DEF  = 4;
  localparam int DASH_MIN_DEF  = 30;
  localparam int CHAR_GAP_DEF  = 30;
  localparam int WORD_GAP_DEF  = 70;
  localparam int STUCK_MAX_DEF = 200;

endpackage

// File: rtl/key_debounce.sv
// Key conditioning: a 2-flop synchronizer followed by a stable-cycle debouncer.
// key only follows the synchronized level after it has differed for DEBOUNCE cycles.
module key_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key,
  output logic key_sync,
  output logic sync_valid
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);

  logic            sync_1;
  logic [1:0]      fill;
  logic [DB_W-1:0] stable_cnt;

  // fill marks when key_sync holds a real sample of key_raw rather than its reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1   <= 1'b0;
      key_sync <= 1'b0;
      fill     <= 2'b00;
    end else begin
      sync_1   <= key_raw;
      key_sync <= sync_1;
      fill     <= {fill[0], 1'b1};
    end
  end

  assign sync_valid = fill[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key        <= 1'b0;
      stable_cnt <= '0;
    end else if (key_sync == key) begin
      stable_cnt <= '0;
    end else if (stable_cnt == DB_W'(DEBOUNCE - 1)) begin
      key        <= key_sync;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + DB_W'(1);
    end
  end

endmodule

// File: rtl/morse_key_timer.sv
// Morse key timing front end: measures press and gap durations with one shared
// saturating counter and emits registered one-cycle symbol, gap and stuck-key pulses.
//
//   state | meaning
//   IDLE  | key released, no gap being timed; cnt held at 0
//   PRESS | key down, cnt counts press length
//   GAP   | key up after a symbol, cnt counts gap length
//   STUCK | press exceeded STUCK_MAX, waiting for release
module morse_key_timer
  import morse_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DEBOUNCE  = DEBOUNCE_DEF,
  parameter int DASH_MIN  = DASH_MIN_DEF,
  parameter int CHAR_GAP  = CHAR_GAP_DEF,
  parameter int WORD_GAP  = WORD_GAP_DEF,
  parameter int STUCK_MAX = STUCK_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  input  logic tm_reset,
  output logic key,
  output logic sym_valid,
  output logic sym_dash,
  output logic char_end,
  output logic word_end,
  output logic stuck_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DASH_C  = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] CHAR_C  = CNT_W'(CHAR_GAP);
  localparam logic [CNT_W-1:0] WORD_C  = CNT_W'(WORD_GAP);
  localparam logic [CNT_W-1:0] STUCK_C = CNT_W'(STUCK_MAX);

  logic             key_sync;
  logic             sync_valid;
  logic             key_d;
  logic             armed;
  logic             key_rise;
  logic             key_fall;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             char_sent, char_sent_nxt;
  logic             sym_valid_nxt, sym_dash_nxt;
  logic             char_end_nxt, word_end_nxt, stuck_err_nxt;

  key_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_key_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .key        (key),
    .key_sync   (key_sync),
    .sync_valid (sync_valid)
  );

  assign key_rise = key & ~key_d;
  assign key_fall = ~key & key_d;
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // A key already held through reset must be seen released before a press is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_d <= 1'b0;
      armed <= 1'b0;
    end else begin
      key_d <= key;
      armed <= armed | (sync_valid & ~key_sync & ~key);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      char_sent <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      char_sent <= char_sent_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    char_sent_nxt = char_sent;
    sym_valid_nxt = 1'b0;
    sym_dash_nxt  = 1'b0;
    char_end_nxt  = 1'b0;
    word_end_nxt  = 1'b0;
    stuck_err_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (key_rise && armed) state_nxt = PRESS;
      end
      PRESS: begin
        cnt_nxt = cnt_inc;
        if (key_fall) begin
          sym_valid_nxt = 1'b1;
          sym_dash_nxt  = (cnt >= DASH_C);
          state_nxt     = GAP;
        end else if (cnt == STUCK_C && !tm_reset) begin
          stuck_err_nxt = 1'b1;
          state_nxt     = STUCK;
        end
      end
      GAP: begin
        cnt_nxt = cnt_inc;
        if (key_rise) begin
          state_nxt = PRESS;
        end else if (!tm_reset) begin
          if (cnt == WORD_C) begin
            word_end_nxt = 1'b1;
            state_nxt    = IDLE;
          end else if (cnt == CHAR_C && !char_sent) begin
            char_end_nxt  = 1'b1;
            char_sent_nxt = 1'b1;
          end
        end
      end
      STUCK: begin
        cnt_nxt = '0;
        if (key_fall) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (state_nxt != state) begin
      cnt_nxt       = '0;
      char_sent_nxt = 1'b0;
    end
    if (tm_reset) cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_valid <= 1'b0;
      sym_dash  <= 1'b0;
      char_end  <= 1'b0;
      word_end  <= 1'b0;
      stuck_err <= 1'b0;
    end else begin
      sym_valid <= sym_valid_nxt;
      sym_dash  <= sym_dash_nxt;
      char_end  <= char_end_nxt;
      word_end  <= word_end_nxt;
      stuck_err <= stuck_err_nxt;
    end
  end

endmodule

// File: doc/morse_key_timer.md
# morse_key_timer

Timing front end for the Morse texter. Conditions the raw key switch and measures key-down and key-up durations with one shared counter. Classifies each press as dit or dash, and flags character gaps, word gaps and stuck-key errors. Its one-cycle pulses drive the texter control FSM, and that FSM can restart the counter through `tm_reset`.

## Interface

Parameters:
- `CNT_W`, 8: width of the duration counter; the counter saturates at 2^CNT_W−1.
- `DEBOUNCE`, 4: number of cycles the synchronized key must stay stable before the debounced key changes.
- `DASH_MIN`, 30: press count at or above which a press is a dash.
- `CHAR_GAP`, 30: key-up count that ends a character.
- `WORD_GAP`, 70: key-up count that ends a word; must satisfy CHAR_GAP < WORD_GAP ≤ 2^CNT_W−1.
- `STUCK_MAX`, 200: key-down count that raises a stuck-key error; must satisfy DASH_MIN < STUCK_MAX ≤ 2^CNT_W−1.

Ports:
- `clk`, in, 1: single system clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `key_raw`, in, 1: raw key switch, asynchronous to `clk`.
- `tm_reset`, in, 1: synchronous counter clear requested by the control FSM.
- `key`, out, 1: debounced key level.
- `sym_valid`, out, 1: one-cycle pulse marking a completed press.
- `sym_dash`, out, 1: press class, 1 = dash and 0 = dit; valid only while `sym_valid` is high.
- `char_end`, out, 1: one-cycle pulse when the key-up count reaches CHAR_GAP.
- `word_end`, out, 1: one-cycle pulse when the key-up count reaches WORD_GAP.
- `stuck_err`, out, 1: one-cycle pulse when the key-down count reaches STUCK_MAX.

## Operation

- **Conditioning:** `key_raw` passes through a 2-flop synchronizer and then the debouncer. `key` changes only after the synchronized level has differed from `key` for DEBOUNCE consecutive cycles.
- **Counter:** `cnt` is CNT_W bits, unsigned and saturating. It clears to 0 on every state entry and on `tm_reset`.
- **IDLE:** `cnt` holds at 0. A rising edge on `key` moves to PRESS.
- **PRESS:** `cnt` increments each cycle.
  - Falling edge on `key`: pulse `sym_valid` with `sym_dash` = (cnt ≥ DASH_MIN), then move to GAP.
  - `cnt` reaches STUCK_MAX: pulse `stuck_err`, then move to STUCK.
- **STUCK:** waits for a falling edge on `key`, then returns to IDLE without emitting a symbol.
- **GAP:** `cnt` increments each cycle.
  - `cnt` reaches CHAR_GAP: pulse `char_end` once.
  - `cnt` reaches WORD_GAP: pulse `word_end`, then move to IDLE.
  - Rising edge on `key`: move to PRESS. No further gap pulses are emitted for this gap.
- **Simultaneous events:**
  - `tm_reset` in the same cycle as a threshold crossing: the clear wins and no pulse is emitted.
  - `tm_reset` in the same cycle as a key edge: the edge transition still happens.
- **Saturation:** `cnt` never wraps. STUCK_MAX and WORD_GAP are reached before saturation by construction.
- **Reset:** assertion clears all outputs, the synchronizer, the debouncer, `cnt` and the state (to IDLE) immediately. A press already in progress when reset releases is ignored until `key` has been seen low.

## Timing

- All outputs are registered.
- Each pulse is high for exactly one cycle, in the cycle after the edge or threshold cycle that causes it.
- `key_raw` to `key` latency is 2 + DEBOUNCE cycles.
- The `key` falling edge to `sym_valid` latency is 1 cycle.
- `sym_dash` is stable only while `sym_valid` is high; it is 0 otherwise.
- `char_end` and `word_end` are never asserted in the same cycle.
- `sym_valid` and `char_end` are never asserted in the same cycle.
- The consumer of these pulses needs no handshake; every pulse is lost if it is not sampled.

## Structure

- Shared package `morse_pkg` holds:
  - the state enum (IDLE, PRESS, GAP, STUCK);
  - the default threshold constants, which `texter_control` also uses.
- Sub-module `key_debounce` contains the synchronizer, the stable-cycle counter and the `key` output register.
- The top level contains the FSM, the duration counter and the pulse registers.

## Test plan

All scenarios use the default parameters.

- **Reset:** assert `rst_n` = 0 with `key_raw` = 1 → all outputs 0 and state IDLE. Release reset, then release the key → no pulses.
- **Dit and dash:** a 10-cycle press → one `sym_valid` with `sym_dash` = 0. A 40-cycle press → `sym_dash` = 1. A press of exactly 30 counts → dash.
- **Debounce:** a 2-cycle glitch on `key_raw` → `key` is unchanged and no pulses occur. A stable high → `key` rises 6 cycles later.
- **Gaps:** a dit followed by 100 idle cycles → `char_end` exactly once at gap count 30, `word_end` once at count 70, then IDLE. A new press at gap count 50 → no `word_end`.
- **Stuck key:** hold for 250 cycles → `stuck_err` at count 200, and no `sym_valid` on release.
- **tm_reset:** assert `tm_reset` at gap count 29 → `char_end` is delayed to 30 cycles after the clear. Assert `rst_n` low mid-PRESS → outputs clear asynchronously.
